// File: rtl/dprambe.sv
// Simple dual-port RAM with byte enables, optional output register and optional clear sequencer (DPRAMBE_CLEAR_EN).
// Latency: read data valid 1 cycle after re (REGOUT="N") or 2 cycles (REGOUT="Y"); writes take effect at the clock edge.
// Backpressure: none on the data path; while busy is high (clear running) read and write requests are dropped.
module dprambe #(
    parameter int    DWIDTH    = 128,
    parameter int    AWIDTH    = 4,
    parameter string REGOUT    = "Y",
    parameter string RDW_MODE  = "NEW",
    parameter string INIT_FILE = "",
    parameter int    BEWIDTH   = DWIDTH / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AWIDTH-1:0]  waddr,
    input  logic [DWIDTH-1:0]  wdata,
    input  logic [BEWIDTH-1:0] be,
    input  logic               re,
    input  logic [AWIDTH-1:0]  raddr,
    output logic [DWIDTH-1:0]  q,
    output logic               q_valid,
    output logic               busy
);

    localparam int DEPTH   = 1 << AWIDTH;
    localparam bit RDW_NEW = (RDW_MODE == "NEW");

    // Parameter legality is checked at elaboration so a bad build never reaches simulation.
    if ((DWIDTH % 8 != 0) || (BEWIDTH * 8 != DWIDTH)) begin : g_err_width
        $error("dprambe: DWIDTH must be a multiple of 8 with BEWIDTH = DWIDTH/8");
    end
    if ((RDW_MODE != "NEW") && (RDW_MODE != "OLD")) begin : g_err_rdw
        $error("dprambe: RDW_MODE must be \"NEW\" or \"OLD\"");
    end
    if ((REGOUT != "Y") && (REGOUT != "N")) begin : g_err_regout
        $error("dprambe: REGOUT must be \"Y\" or \"N\"");
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              busy_i;
    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;
    logic              wr_fire;
    logic              rd_fire;
    logic [DWIDTH-1:0] rd_word;
    logic              rd1_vld;
    logic [DWIDTH-1:0] rd1_dat;

    assign wr_fire = we & ~busy_i;
    assign rd_fire = re & ~busy_i;
    assign busy    = busy_i;

`ifdef DPRAMBE_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] cnt;
    logic [AWIDTH-1:0] cnt_nxt;

    // Clear sequencer state: reset always restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep one word per cycle; leave CLEAR after the last address is zeroed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        if (state == ST_CLEAR) begin
            clr_we  = ~rst;
            cnt_nxt = cnt + AWIDTH'(1);
            if (cnt == AWIDTH'(DEPTH - 1)) begin
                state_nxt = ST_READY;
            end
        end
    end

    assign busy_i   = (state == ST_CLEAR);
    assign clr_addr = cnt;
`else
    assign busy_i   = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Write port: clear sweep has priority, otherwise byte-lane masked user write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BEWIDTH; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read word with optional bypass of a same-address write (merged per enabled byte).
    always_comb begin
        rd_word = mem[raddr];
        if (RDW_NEW && wr_fire && (waddr == raddr)) begin
            for (int i = 0; i < BEWIDTH; i++) begin
                if (be[i]) begin
                    rd_word[i*8 +: 8] = wdata[i*8 +: 8];
                end
            end
        end
    end

    // First read stage: capture data only when a read fires so q holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_vld <= 1'b0;
            rd1_dat <= '0;
        end else begin
            rd1_vld <= rd_fire;
            if (rd_fire) begin
                rd1_dat <= rd_word;
            end
        end
    end

    if (REGOUT == "Y") begin : g_regout
        logic [DWIDTH-1:0] q_r;
        logic              q_vld_r;

        // Output register stage: second read in flight lives here.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_r     <= '0;
                q_vld_r <= 1'b0;
            end else begin
                q_vld_r <= rd1_vld;
                if (rd1_vld) begin
                    q_r <= rd1_dat;
                end
            end
        end

        assign q       = q_r;
        assign q_valid = q_vld_r;
    end else begin : g_noreg
        assign q       = rd1_dat;
        assign q_valid = rd1_vld;
    end

endmodule

// File: tb/tb_dprambe.sv
module tb_dprambe;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int NI    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] q_o    [NI];
    logic          qv_o   [NI];
    logic          busy_o [NI];

    int checks   = 0;
    int failures = 0;

    // Instance 0: registered output, new-data read-during-write
    dprambe #(.DWIDTH(DW), .AWIDTH(AW), .REGOUT("Y"), .RDW_MODE("NEW"), .INIT_FILE(""), .BEWIDTH(BW)) u_yn (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .be(be), .re(re), .raddr(raddr),
        .q(q_o[0]), .q_valid(qv_o[0]), .busy(busy_o[0]));
    // Instance 1: registered output, old-data read-during-write
    dprambe #(.DWIDTH(DW), .AWIDTH(AW), .REGOUT("Y"), .RDW_MODE("OLD"), .INIT_FILE(""), .BEWIDTH(BW)) u_yo (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .be(be), .re(re), .raddr(raddr),
        .q(q_o[1]), .q_valid(qv_o[1]), .busy(busy_o[1]));
    // Instance 2: unregistered output, new-data read-during-write
    dprambe #(.DWIDTH(DW), .AWIDTH(AW), .REGOUT("N"), .RDW_MODE("NEW"), .INIT_FILE(""), .BEWIDTH(BW)) u_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .be(be), .re(re), .raddr(raddr),
        .q(q_o[2]), .q_valid(qv_o[2]), .busy(busy_o[2]));

    always #5 clk = ~clk;

    // Reference model: flat memory, per-instance results scheduled by issue cycle + latency
    logic [DW-1:0] mem_m [DEPTH];
    logic          sv    [NI][4];
    logic [DW-1:0] sd    [NI][4];
    logic [DW-1:0] q_exp [NI];
    logic          busy_exp = 1'b0;
    int            clr_rem  = 0;
    int            cyc      = 0;
    int            lat  [NI] = '{2, 2, 1};
    bit            newm [NI] = '{1'b1, 1'b0, 1'b1};
    string         nm   [NI] = '{"yn", "yo", "n"};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] dat,
                                            input logic [BW-1:0] en);
        logic [DW-1:0] r = old;
        for (int i = 0; i < BW; i++) if (en[i]) r[i*8 +: 8] = dat[i*8 +: 8];
        return r;
    endfunction

    // Effect of the coming clock edge on the model, computed from the inputs now driven
    task automatic model_apply();
        int due;
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                q_exp[k] = '0;
                for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            end
`ifdef DPRAMBE_CLEAR_EN
            clr_rem = DEPTH;
`endif
        end else begin
            if (!busy_exp) begin
                if (re) begin
                    for (int k = 0; k < NI; k++) begin
                        due = (cyc + lat[k]) % 4;
                        sv[k][due] = 1'b1;
                        sd[k][due] = (newm[k] && we && waddr == raddr) ?
                                     merge(mem_m[raddr], wdata, be) : mem_m[raddr];
                    end
                end
                if (we) mem_m[waddr] = merge(mem_m[waddr], wdata, be);
            end
            if (clr_rem > 0) begin
                mem_m[DEPTH - clr_rem] = '0;
                clr_rem--;
            end
        end
        busy_exp = (clr_rem > 0);
    endtask

    task automatic tick();
        int slot;
        logic ev;
        model_apply();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        slot = cyc % 4;
        for (int k = 0; k < NI; k++) begin
            ev = sv[k][slot];
            if (ev) begin
                q_exp[k]    = sd[k][slot];
                sv[k][slot] = 1'b0;
            end
            chk({nm[k], "_qvalid"}, {31'd0, qv_o[k]}, {31'd0, ev});
            chk({nm[k], "_q"}, q_o[k], q_exp[k]);
            chk({nm[k], "_busy"}, {31'd0, busy_o[k]}, {31'd0, busy_exp});
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [BW-1:0] b, input logic r, input logic [AW-1:0] ra);
        we = w; waddr = wa; wdata = wd; be = b; re = r; raddr = ra;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && busy_exp; i++) tick();
    endtask

    initial begin
        int            n;
        logic [DW-1:0] vals [3];
        logic [AW-1:0] a;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        for (int k = 0; k < NI; k++) begin
            q_exp[k] = '0;
            for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
        end
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_q", q_o[0], 32'h0);
        chk("rst_qvalid", {31'd0, qv_o[2]}, 32'h0);
        rst = 1'b0;
        wait_ready();

        // Full write then read: data appears 2 cycles after re on the registered instance
        drive(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, '0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 4'd3);
        tick();
        chk("lat_c1_qvalid", {31'd0, qv_o[0]}, 32'h0);
        idle();
        tick();
        chk("lat_c2_qvalid", {31'd0, qv_o[0]}, 32'h1);
        chk("lat_c2_q", q_o[0], 32'hAABBCCDD);

        // Partial write of lanes 0 and 2
        drive(1'b1, 4'd3, 32'h11223344, 4'h5, 1'b0, '0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 4'd3);
        tick();
        idle();
        tick();
        chk("partial_q", q_o[0], 32'hAA22CC44);

        // Read-during-write on address 5
        drive(1'b1, 4'd5, 32'h12345678, 4'hF, 1'b0, '0);
        tick();
        drive(1'b1, 4'd5, 32'h0000FFFF, 4'h3, 1'b1, 4'd5);
        tick();
        chk("rdw_n_new_q", q_o[2], 32'h1234FFFF);
        idle();
        tick();
        chk("rdw_y_new_q", q_o[0], 32'h1234FFFF);
        chk("rdw_y_old_q", q_o[1], 32'h12345678);

        // Back-to-back reads of 0,1,2 on the unregistered instance
        vals[0] = 32'hC0DE0000; vals[1] = 32'hC0DE1111; vals[2] = 32'hC0DE2222;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(i), vals[i], 4'hF, 1'b0, '0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            tick();
            chk("b2b_n_qvalid", {31'd0, qv_o[2]}, 32'h1);
            chk("b2b_n_q", q_o[2], vals[i]);
        end
        idle();
        tick();
        chk("b2b_n_end_qvalid", {31'd0, qv_o[2]}, 32'h0);
        chk("b2b_n_hold_q", q_o[2], vals[2]);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                idle();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                a = AW'($urandom_range(0, DEPTH - 1));
                drive(1'($urandom_range(0, 1)), a, DW'($urandom), BW'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, DEPTH - 1)));
                tick();
            end
        end
        idle();
        tick();
        tick();
        wait_ready();

`ifdef DPRAMBE_CLEAR_EN
        // Clear after reset: busy for 16 cycles, reads while busy produce nothing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = busy_o[0] ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'($urandom_range(0, DEPTH - 1)));
            tick();
            if (busy_o[0]) n++;
            else break;
        end
        chk("clr_busy_cycles", n, 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            tick();
        end
        idle();
        tick();
        tick();
        chk("clr_last_q", q_o[0], 32'h0);

        // Reset reasserted at clear cycle 7 restarts the full sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = busy_o[0] ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy_o[0]) n++;
            else break;
        end
        chk("clr_restart_busy_cycles", n, 32'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dprambe.md
DPRAMBE -- requirements
Module: dprambe

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 128: data width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter AWIDTH, default 4: address width; DEPTH = 2**AWIDTH words.
REQ-003 The block SHALL have parameter REGOUT, default "Y": "Y" adds an output register stage; "N" does not.
REQ-004 The block SHALL have parameter RDW_MODE, default "NEW": read-during-write result, either "NEW" or "OLD".
REQ-005 The block SHALL have parameter INIT_FILE, default "": hex image loaded at time zero when non-empty.
REQ-006 The block SHALL have parameter BEWIDTH, default DWIDTH/8: number of byte lanes.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 The block SHALL have port we, input, 1 bit: write request.
REQ-010 The block SHALL have port waddr, input, AWIDTH bits: write address.
REQ-011 The block SHALL have port wdata, input, DWIDTH bits: write data; byte i is bits i*8+7..i*8.
REQ-012 The block SHALL have port be, input, BEWIDTH bits: byte enables for the write.
REQ-013 The block SHALL have port re, input, 1 bit: read request.
REQ-014 The block SHALL have port raddr, input, AWIDTH bits: read address.
REQ-015 The block SHALL have port q, output, DWIDTH bits: read data.
REQ-016 The block SHALL have port q_valid, output, 1 bit: one-cycle pulse marking q as new read data.
REQ-017 The block SHALL have port busy, output, 1 bit: clear in progress; requests are ignored while it is high.

Function
REQ-018 The block SHALL write byte i of mem[waddr] from wdata byte i on a clock edge when we=1, be[i]=1 and busy=0; other bytes stay unchanged.
REQ-019 The block SHALL sample a read when re=1 and busy=0, with latency L=1 for REGOUT="N" and L=2 for REGOUT="Y", with q_valid asserted in the same cycle that q updates.
REQ-020 The block SHALL hold q at its last value when no read completes; q_valid SHALL be 0 in those cycles.
REQ-021 When a read and a write hit the same address in the same cycle with RDW_MODE="NEW", q SHALL equal the merged word: enabled bytes from wdata, the rest from the old contents.
REQ-022 When a read and a write hit the same address in the same cycle with RDW_MODE="OLD", q SHALL equal the contents before the write.
REQ-023 The block SHALL accept back-to-back reads every cycle and pipeline them; with REGOUT="Y", two reads SHALL be in flight.
REQ-024 Address arithmetic SHALL be modulo DEPTH; the block SHALL have no out-of-range condition.
REQ-025 The block SHALL raise an elaboration error when DWIDTH%8 != 0, or when RDW_MODE or REGOUT is not one of its legal values.

Reset
REQ-026 With rst=1 at a clock edge, the block SHALL set q=0 and q_valid=0 and flush the read pipeline; busy follows REQ-028/029.
REQ-027 Memory contents SHALL NOT be altered by reset alone, except by the clear sequencer of REQ-028.

Configuration
REQ-028 With DPRAMBE_CLEAR_EN defined, the block SHALL include a clear FSM: rst sets state CLEAR with counter 0 and busy=1; each CLEAR cycle writes all-zero to mem[counter] and increments the counter; after writing DEPTH-1 the FSM SHALL move to READY and busy SHALL drop on the next cycle; reset during CLEAR SHALL restart from address 0; the clear takes exactly DEPTH cycles after rst deasserts.
REQ-029 Without DPRAMBE_CLEAR_EN, the block SHALL tie busy to 0, include no FSM, and keep INIT_FILE contents across reset.

Verification
REQ-030 The bench SHALL cover: DWIDTH=32, REGOUT="Y", write 0xAABBCCDD at addr 3 with be=0xF, then read addr 3 -> q=0xAABBCCDD with q_valid exactly 2 cycles after re.
REQ-031 The bench SHALL cover: a partial write of 0x11223344 to addr 3 with be=0x5 -> a read returns 0xAA22CC44.
REQ-032 The bench SHALL cover: a same-cycle write of 0x0000FFFF with be=0x3 and read of addr 5, where addr 5 held 0x12345678 -> "NEW" gives 0x1234FFFF and "OLD" gives 0x12345678.
REQ-033 The bench SHALL cover: CLEAR_EN, AWIDTH=4, rst pulse -> busy high for 16 cycles, every address reads 0; a re issued while busy gives no q_valid.
REQ-034 The bench SHALL cover: CLEAR_EN, rst reasserted at clear cycle 7 -> busy stays high for 16 cycles after the second rst.
REQ-035 The bench SHALL cover: REGOUT="N", reads to addrs 0,1,2 on consecutive cycles -> three consecutive q_valid pulses with the matching data at 1-cycle latency.
